// File: rtl/traffic_lights_pkg.sv
// Shared types for the traffic light command path: command encoding, host modes,
// sequencer states and the captured duration bundle.
package traffic_lights_pkg;

  localparam int CMD_DATA_W = 16;

  typedef enum logic [2:0] {
    CMD_ON         = 3'd0,
    CMD_OFF        = 3'd1,
    CMD_UNREG      = 3'd2,
    CMD_SET_GREEN  = 3'd3,
    CMD_SET_RED    = 3'd4,
    CMD_SET_YELLOW = 3'd5
  } cmd_type_t;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_OFF     = 2'd1,
    MODE_UNREG   = 2'd2,
    MODE_ILLEGAL = 2'd3
  } req_mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_G,
    S_SEND_R,
    S_SEND_Y,
    S_SEND_MODE,
    S_GAP
  } seq_state_t;

  typedef struct packed {
    logic [CMD_DATA_W-1:0] green;
    logic [CMD_DATA_W-1:0] red;
    logic [CMD_DATA_W-1:0] yellow;
  } dur_t;

  // A zero-length phase would stall the lamp controller, so it becomes 1 ms.
  function automatic logic [CMD_DATA_W-1:0] clamp_dur(input logic [CMD_DATA_W-1:0] d);
    return (d == '0) ? CMD_DATA_W'(1) : d;
  endfunction

  function automatic req_mode_t cmd2mode(input cmd_type_t c);
    case (c)
      CMD_ON:    return MODE_RUN;
      CMD_UNREG: return MODE_UNREG;
      default:   return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/tl_wdog.sv
// Host-activity watchdog: counts enabled cycles, pulses expire on the last one.
module tl_wdog #(
  parameter int unsigned WDOG_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (clear || !enable) cnt_d = '0;
  end

  // A clear in the terminal cycle wins, so a late kick still rescues the host.
  assign expire = (WDOG_CYCLES != 0) && enable && !clear &&
                  (cnt_q == 32'(WDOG_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_lights_cmd_seq.sv
// Turns a host mode/duration request into a spaced single-cycle command stream
// for the lamp controller, with watchdog fallback to yellow-blink.
module traffic_lights_cmd_seq
  import traffic_lights_pkg::*;
#(
  parameter int unsigned CMD_GAP     = 2,
  parameter int unsigned WDOG_CYCLES = 1000
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_mode_i,
  input  logic [CMD_DATA_W-1:0] req_green_ms_i,
  input  logic [CMD_DATA_W-1:0] req_red_ms_i,
  input  logic [CMD_DATA_W-1:0] req_yellow_ms_i,
  input  logic                  kick_i,
  output logic [2:0]            cmd_type_o,
  output logic                  cmd_valid_o,
  output logic [CMD_DATA_W-1:0] cmd_data_o,
  output logic                  busy_o,
  output logic                  wdog_trip_o
);

  localparam logic [15:0] GAP_LOAD = 16'(CMD_GAP - 1);

  seq_state_t            state_q, state_d, ret_q, ret_d, tgt;
  logic [15:0]           gap_q, gap_d;
  dur_t                  dur_q, dur_d;
  cmd_type_t             mode_cmd_q, mode_cmd_d;
  req_mode_t             active_q, active_d, req_mode;
  logic                  trip_q, trip_d;
  logic                  cmd_valid_q, cmd_valid_d;
  cmd_type_t             cmd_type_q, cmd_type_d;
  logic [CMD_DATA_W-1:0] cmd_data_q, cmd_data_d;
  logic                  accept, adv, wdog_en, wdog_clr, wdog_expire;

  assign req_mode    = req_mode_t'(req_mode_i);
  assign accept      = req_valid_i && (state_q == S_IDLE);
  assign wdog_en     = (state_q == S_IDLE) && (active_q == MODE_RUN);
  assign wdog_clr    = kick_i || accept;

  tl_wdog #(.WDOG_CYCLES(WDOG_CYCLES)) u_wdog (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .enable  (wdog_en),
    .clear   (wdog_clr),
    .expire  (wdog_expire)
  );

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    gap_d       = gap_q;
    dur_d       = dur_q;
    mode_cmd_d  = mode_cmd_q;
    active_d    = active_q;
    trip_d      = trip_q;
    cmd_valid_d = 1'b0;
    cmd_type_d  = CMD_ON;
    cmd_data_d  = '0;
    adv         = 1'b0;
    tgt         = S_IDLE;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_mode != MODE_ILLEGAL) begin
            trip_d = 1'b0;
            case (req_mode)
              MODE_RUN: begin
                dur_d.green  = clamp_dur(req_green_ms_i);
                dur_d.red    = clamp_dur(req_red_ms_i);
                dur_d.yellow = clamp_dur(req_yellow_ms_i);
                mode_cmd_d   = CMD_ON;
                state_d      = S_SEND_G;
              end
              MODE_OFF: begin
                mode_cmd_d = CMD_OFF;
                state_d    = S_SEND_MODE;
              end
              default: begin
                mode_cmd_d = CMD_UNREG;
                state_d    = S_SEND_MODE;
              end
            endcase
          end
        end else if (wdog_expire) begin
          mode_cmd_d = CMD_UNREG;
          trip_d     = 1'b1;
          state_d    = S_SEND_MODE;
        end
      end
      S_SEND_G:    begin adv = 1'b1; tgt = S_SEND_R;    end
      S_SEND_R:    begin adv = 1'b1; tgt = S_SEND_Y;    end
      S_SEND_Y:    begin adv = 1'b1; tgt = S_SEND_MODE; end
      S_SEND_MODE: begin adv = 1'b1; tgt = S_IDLE;      end
      S_GAP: begin
        if (gap_q == '0) state_d = ret_q;
        else             gap_d   = gap_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      if (CMD_GAP == 0) begin
        state_d = tgt;
      end else begin
        state_d = S_GAP;
        ret_d   = tgt;
        gap_d   = GAP_LOAD;
      end
    end

    // Outputs are registered from the next state so a command appears the
    // cycle its SEND state is entered.
    case (state_d)
      S_SEND_G: begin
        cmd_valid_d = 1'b1;
        cmd_type_d  = CMD_SET_GREEN;
        cmd_data_d  = dur_d.green;
      end
      S_SEND_R: begin
        cmd_valid_d = 1'b1;
        cmd_type_d  = CMD_SET_RED;
        cmd_data_d  = dur_d.red;
      end
      S_SEND_Y: begin
        cmd_valid_d = 1'b1;
        cmd_type_d  = CMD_SET_YELLOW;
        cmd_data_d  = dur_d.yellow;
      end
      S_SEND_MODE: begin
        cmd_valid_d = 1'b1;
        cmd_type_d  = mode_cmd_d;
        active_d    = cmd2mode(mode_cmd_d);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      gap_q       <= '0;
      dur_q       <= '0;
      mode_cmd_q  <= CMD_OFF;
      active_q    <= MODE_OFF;
      trip_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= CMD_ON;
      cmd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      gap_q       <= gap_d;
      dur_q       <= dur_d;
      mode_cmd_q  <= mode_cmd_d;
      active_q    <= active_d;
      trip_q      <= trip_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_data_q  <= cmd_data_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign busy_o      = !req_ready_o;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_type_o  = cmd_type_q;
  assign cmd_data_o  = cmd_data_q;
  assign wdog_trip_o = trip_q;

endmodule

// File: tb/tb_traffic_lights_cmd_seq.sv
// Scoreboard bench: two sequencers (gap 2 with a 50-cycle watchdog, gap 0 without).
module tb_traffic_lights_cmd_seq;

  localparam int GA = 2;
  localparam int GB = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       req_valid, kick, req_ready, cmd_valid, busy, trip;
  logic [1:0][1:0]  req_mode;
  logic [1:0][15:0] req_g, req_r, req_y, cmd_data;
  logic [1:0][2:0]  cmd_type;

  traffic_lights_cmd_seq #(.CMD_GAP(GA), .WDOG_CYCLES(50)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_mode_i(req_mode[0]), .req_green_ms_i(req_g[0]), .req_red_ms_i(req_r[0]),
    .req_yellow_ms_i(req_y[0]), .kick_i(kick[0]), .cmd_type_o(cmd_type[0]),
    .cmd_valid_o(cmd_valid[0]), .cmd_data_o(cmd_data[0]), .busy_o(busy[0]),
    .wdog_trip_o(trip[0]));

  traffic_lights_cmd_seq #(.CMD_GAP(GB), .WDOG_CYCLES(0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_mode_i(req_mode[1]), .req_green_ms_i(req_g[1]), .req_red_ms_i(req_r[1]),
    .req_yellow_ms_i(req_y[1]), .kick_i(kick[1]), .cmd_type_o(cmd_type[1]),
    .cmd_valid_o(cmd_valid[1]), .cmd_data_o(cmd_data[1]), .busy_o(busy[1]),
    .wdog_trip_o(trip[1]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  typ;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic void check(bit ok, string name, int act, int req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void push(int d, logic [2:0] ty, logic [15:0] da, int c);
    exp_t e;
    e.typ = ty; e.data = da; e.cyc = c;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic logic [15:0] clamp(logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

  // Pushes the commands a request accepted at cycle t must produce; returns the ready cycle.
  function automatic int push_seq(int d, logic [1:0] m, int t, logic [15:0] g, logic [15:0] r,
                                  logic [15:0] y);
    int G;
    G = (d == 0) ? GA : GB;
    case (m)
      2'd0: begin
        push(d, 3'd3, clamp(g), t + 1);
        push(d, 3'd4, clamp(r), t + 2 + G);
        push(d, 3'd5, clamp(y), t + 3 + 2 * G);
        push(d, 3'd0, 16'd0,    t + 4 + 3 * G);
        return t + 5 + 4 * G;
      end
      2'd1: begin push(d, 3'd1, 16'd0, t + 1); return t + 2 + G; end
      2'd2: begin push(d, 3'd2, 16'd0, t + 1); return t + 2 + G; end
      default: return t + 1;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        check(busy[d] == !req_ready[d], "busy_vs_ready", int'(busy[d]), int'(!req_ready[d]));
        if (cmd_valid[d]) begin
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            check(1'b0, $sformatf("unexpected_cmd_dut%0d", d), int'(cmd_type[d]), -1);
          end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check(cmd_type[d] == e.typ, $sformatf("cmd_type_dut%0d", d), int'(cmd_type[d]), int'(e.typ));
            check(cmd_data[d] == e.data, $sformatf("cmd_data_dut%0d", d), int'(cmd_data[d]), int'(e.data));
            check(cyc == e.cyc, $sformatf("cmd_cycle_dut%0d", d), cyc, e.cyc);
          end
        end else begin
          check(cmd_type[d] == 3'd0 && cmd_data[d] == 16'd0, $sformatf("idle_out_dut%0d", d),
                int'({cmd_type[d], cmd_data[d]}), 0);
        end
      end
    end
  end

  task automatic goto_cycle(int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_ready(int d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[d] && n < 200);
    if (!req_ready[d]) check(1'b0, "ready_timeout", 0, 1);
  endtask

  task automatic do_req(int d, logic [1:0] m, logic [15:0] g, logic [15:0] r, logic [15:0] y,
                        bit wait_done, output int t);
    int rdy;
    @(posedge clk); #1;
    req_mode[d] = m; req_g[d] = g; req_r[d] = r; req_y[d] = y; req_valid[d] = 1'b1;
    wait_ready(d);
    t = cyc;
    rdy = push_seq(d, m, t, g, r, y);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    if (wait_done) begin
      wait_ready(d);
      check(cyc == rdy, $sformatf("ready_return_dut%0d_mode%0d", d, m), cyc, rdy);
    end
  endtask

  task automatic kick_at(int d, int c);
    goto_cycle(c);
    kick[d] = 1'b1;
    @(posedge clk); #1;
    kick[d] = 1'b0;
  endtask

  task automatic check_reset(int d, string tag);
    check(req_ready[d] == 1'b1, {tag, "_ready"}, int'(req_ready[d]), 1);
    check(busy[d] == 1'b0, {tag, "_busy"}, int'(busy[d]), 0);
    check(cmd_valid[d] == 1'b0, {tag, "_valid"}, int'(cmd_valid[d]), 0);
    check(cmd_type[d] == 3'd0, {tag, "_type"}, int'(cmd_type[d]), 0);
    check(cmd_data[d] == 16'd0, {tag, "_data"}, int'(cmd_data[d]), 0);
    check(trip[d] == 1'b0, {tag, "_trip"}, int'(trip[d]), 0);
  endtask

  initial begin
    int t, t2, r, k;
    rst_n = 1'b0;
    req_valid = '0; kick = '0; req_mode = '0; req_g = '0; req_r = '0; req_y = '0;
    repeat (3) @(negedge clk);
    check_reset(0, "por_a");
    check_reset(1, "por_b");
    #2 rst_n = 1'b1;

    // Reset in the middle of a RUN sequence: remaining commands must never appear.
    do_req(0, 2'd0, 16'd10, 16'd20, 16'd3, 1'b0, t);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset(0, "midrst_a");
    q0.delete();
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check(req_ready[0] == 1'b1, "ready_after_release", int'(req_ready[0]), 1);
    repeat (20) @(negedge clk);

    // RUN sequence, then watchdog fallback 50 cycles after returning to IDLE.
    do_req(0, 2'd0, 16'd10, 16'd20, 16'd3, 1'b1, t);
    r = cyc;
    push(0, 3'd2, 16'd0, r + 50);
    goto_cycle(r + 51);
    @(negedge clk);
    check(trip[0] == 1'b1, "wdog_trip_set", int'(trip[0]), 1);
    check(q0.size() == 0, "wdog_cmd_seen", q0.size(), 0);

    // Periodic kicks hold off the watchdog; a kick in the expiry cycle also wins.
    do_req(0, 2'd0, 16'd5, 16'd6, 16'd7, 1'b1, t);
    r = cyc;
    check(trip[0] == 1'b0, "trip_cleared_by_req", int'(trip[0]), 0);
    kick_at(0, r + 39);
    kick_at(0, r + 79);
    kick_at(0, r + 119);
    k = r + 119;
    kick_at(0, k + 50);
    push(0, 3'd2, 16'd0, k + 101);
    goto_cycle(k + 100);
    @(negedge clk);
    check(trip[0] == 1'b0, "no_trip_with_kicks", int'(trip[0]), 0);
    goto_cycle(k + 102);
    @(negedge clk);
    check(trip[0] == 1'b1, "trip_after_kicks_stop", int'(trip[0]), 1);
    check(q0.size() == 0, "late_wdog_cmd_seen", q0.size(), 0);

    // Backpressure: valid held through a sequence while the fields keep changing.
    @(posedge clk); #1;
    req_mode[0] = 2'd0; req_g[0] = 16'd100; req_r[0] = 16'd200; req_y[0] = 16'd300;
    req_valid[0] = 1'b1;
    wait_ready(0);
    t = cyc;
    r = push_seq(0, 2'd0, t, 16'd100, 16'd200, 16'd300);
    @(posedge clk); #1;
    req_mode[0] = 2'd1; req_g[0] = 16'd11; req_r[0] = 16'd22; req_y[0] = 16'd33;
    goto_cycle(t + 5);
    req_mode[0] = 2'd0; req_g[0] = 16'd7; req_r[0] = 16'd0; req_y[0] = 16'd9;
    wait_ready(0);
    t2 = cyc;
    check(t2 == t + 13, "bp_second_accept", t2, t + 13);
    r = push_seq(0, 2'd0, t2, 16'd7, 16'd0, 16'd9);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_ready(0);
    check(cyc == r, "bp_ready_return", cyc, r);

    // Zero-gap instance: single-strobe modes, clamping and the illegal mode.
    do_req(1, 2'd1, 16'd0, 16'd0, 16'd0, 1'b1, t);
    do_req(1, 2'd2, 16'd0, 16'd0, 16'd0, 1'b1, t);
    do_req(1, 2'd0, 16'd0, 16'd4, 16'hFFFF, 1'b1, t);
    do_req(1, 2'd3, 16'd1, 16'd2, 16'd3, 1'b1, t);
    repeat (10) @(negedge clk);

    check(q0.size() == 0, "queue_a_drained", q0.size(), 0);
    check(q1.size() == 0, "queue_b_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
